// File: rtl/keypad_operand_sequencer.sv
// Keypad front-end sequencer: turns debounced key levels into operand-digit loads,
// an operator latch and a start/done handshake. Optional entry timeout: KEY_TIMEOUT_EN.
module keypad_operand_sequencer #(
   parameter int DIGITS_A    = 4,
   parameter int DIGITS_B    = 4,
   parameter int CNT_W       = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_level,
   input  logic [3:0]       key_code,
   input  logic             op_done,
   output logic             load_a,
   output logic             load_b,
   output logic [3:0]       key_digit,
   output logic             clr_ops,
   output logic [1:0]       op_sel,
   output logic             start,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      OPA  = 3'd1,
      OPB  = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hD;
   localparam logic [3:0] KEY_EQ    = 4'hE;
   localparam logic [CNT_W-1:0] MAX_A = CNT_W'(DIGITS_A);
   localparam logic [CNT_W-1:0] MAX_B = CNT_W'(DIGITS_B);

   state_t           state_q;
   logic             key_prev_q;
   logic             load_a_q, load_b_q, clr_ops_q, start_q, busy_q, result_valid_q;
   logic [3:0]       key_digit_q;
   logic [1:0]       op_sel_q;
   logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

   logic key_evt, is_digit, is_op, is_clear, is_eq, tmo_hit;

   // Rising edge of the debounced level: one event per press, no auto-repeat.
   assign key_evt  = key_level & ~key_prev_q;
   assign is_digit = key_evt && (key_code <= 4'd9);
   assign is_op    = key_evt && (key_code >= 4'hA) && (key_code <= 4'hC);
   assign is_clear = key_evt && (key_code == KEY_CLEAR);
   assign is_eq    = key_evt && (key_code == KEY_EQ);

   // A -> mul (00), B -> add (01), C -> sub (10)
   function automatic logic [1:0] op_of(input logic [3:0] code);
      return code[1:0] + 2'b10;
   endfunction

`ifdef KEY_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;

   assign tmo_hit = ((state_q == OPA) || (state_q == OPB)) && !key_evt &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // Idle counter: cleared by any key event and held at zero outside operand entry,
   // so every entry into OPA/OPB starts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_q <= '0;
      end else if (((state_q == OPA) || (state_q == OPB)) && !key_evt && !tmo_hit) begin
         tmo_q <= tmo_q + 1'b1;
      end else begin
         tmo_q <= '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // NOTE: every register here uses <= so all state updates see the pre-edge values;
   // pulse outputs default low each cycle and are raised only by the branch that needs them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         key_prev_q     <= 1'b0;
         load_a_q       <= 1'b0;
         load_b_q       <= 1'b0;
         clr_ops_q      <= 1'b0;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         key_digit_q    <= '0;
         op_sel_q       <= '0;
         cnt_a_q        <= '0;
         cnt_b_q        <= '0;
      end else begin
         key_prev_q <= key_level;
         load_a_q   <= 1'b0;
         load_b_q   <= 1'b0;
         clr_ops_q  <= 1'b0;
         start_q    <= 1'b0;

         if (tmo_hit) begin
            clr_ops_q <= 1'b1;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            op_sel_q  <= '0;
            state_q   <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (is_digit) begin
                     load_a_q    <= 1'b1;
                     key_digit_q <= key_code;
                     cnt_a_q     <= CNT_W'(1);
                     cnt_b_q     <= '0;
                     state_q     <= OPA;
                  end else if (is_clear) begin
                     clr_ops_q <= 1'b1;
                     cnt_a_q   <= '0;
                     cnt_b_q   <= '0;
                     op_sel_q  <= '0;
                  end
               end

               OPA: begin
                  if (is_digit) begin
                     if (cnt_a_q < MAX_A) begin
                        load_a_q    <= 1'b1;
                        key_digit_q <= key_code;
                        cnt_a_q     <= cnt_a_q + 1'b1;
                     end
                  end else if (is_op) begin
                     op_sel_q <= op_of(key_code);
                     cnt_b_q  <= '0;
                     state_q  <= OPB;
                  end else if (is_clear) begin
                     clr_ops_q <= 1'b1;
                     cnt_a_q   <= '0;
                     cnt_b_q   <= '0;
                     op_sel_q  <= '0;
                     state_q   <= IDLE;
                  end
               end

               OPB: begin
                  if (is_digit) begin
                     if (cnt_b_q < MAX_B) begin
                        load_b_q    <= 1'b1;
                        key_digit_q <= key_code;
                        cnt_b_q     <= cnt_b_q + 1'b1;
                     end
                  end else if (is_op) begin
                     // Operator can still be replaced until the first B digit arrives.
                     if (cnt_b_q == '0) begin
                        op_sel_q <= op_of(key_code);
                     end
                  end else if (is_eq) begin
                     if (cnt_b_q != '0) begin
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                  end else if (is_clear) begin
                     clr_ops_q <= 1'b1;
                     cnt_a_q   <= '0;
                     cnt_b_q   <= '0;
                     op_sel_q  <= '0;
                     state_q   <= IDLE;
                  end
               end

               RUN: begin
                  // Keys are dropped here; the arithmetic unit always runs to completion.
                  if (op_done) begin
                     busy_q         <= 1'b0;
                     result_valid_q <= 1'b1;
                     state_q        <= DONE;
                  end
               end

               DONE: begin
                  if (is_digit) begin
                     clr_ops_q      <= 1'b1;
                     load_a_q       <= 1'b1;
                     key_digit_q    <= key_code;
                     result_valid_q <= 1'b0;
                     cnt_a_q        <= CNT_W'(1);
                     cnt_b_q        <= '0;
                     state_q        <= OPA;
                  end else if (is_clear) begin
                     clr_ops_q      <= 1'b1;
                     result_valid_q <= 1'b0;
                     cnt_a_q        <= '0;
                     cnt_b_q        <= '0;
                     op_sel_q       <= '0;
                     state_q        <= IDLE;
                  end
               end

               default: begin
                  clr_ops_q      <= 1'b1;
                  busy_q         <= 1'b0;
                  result_valid_q <= 1'b0;
                  cnt_a_q        <= '0;
                  cnt_b_q        <= '0;
                  op_sel_q       <= '0;
                  state_q        <= IDLE;
               end
            endcase
         end
      end
   end

   assign load_a       = load_a_q;
   assign load_b       = load_b_q;
   assign key_digit    = key_digit_q;
   assign clr_ops      = clr_ops_q;
   assign op_sel       = op_sel_q;
   assign start        = start_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign cnt_a        = cnt_a_q;
   assign cnt_b        = cnt_b_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_keypad_operand_sequencer.sv
// Directed bench for keypad_operand_sequencer; define KEY_TIMEOUT_EN to add the timeout steps.
module tb_keypad_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_level = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       op_done = 1'b0;
   logic       load_a, load_b, clr_ops, start, busy, result_valid;
   logic [3:0] key_digit, cnt_a, cnt_b;
   logic [1:0] op_sel;
   logic [2:0] state_o;

   int errors = 0;
   int checks = 0;
   int pulses;

   always #5 clk = ~clk;

   keypad_operand_sequencer #(
      .DIGITS_A(4), .DIGITS_B(4), .CNT_W(4), .TIMEOUT_CYC(20)
   ) dut (
      .clk(clk), .rst(rst), .key_level(key_level), .key_code(key_code),
      .op_done(op_done), .load_a(load_a), .load_b(load_b), .key_digit(key_digit),
      .clr_ops(clr_ops), .op_sel(op_sel), .start(start), .busy(busy),
      .result_valid(result_valid), .cnt_a(cnt_a), .cnt_b(cnt_b), .state_o(state_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise the key at a falling edge and sample the registered response after the next rise.
   task automatic press(input logic [3:0] code);
      @(negedge clk);
      key_code  = code;
      key_level = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic release_key();
      @(negedge clk);
      key_level = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_state", state_o, 0);
      check("rst_busy", busy, 0);
      check("rst_outs", {load_a, load_b, clr_ops, start, result_valid, op_sel, cnt_a, cnt_b}, 0);
      @(negedge clk);
      rst = 1'b1;

      // 1,2,A,3,E with op_done 5 cycles after start
      press(4'h1);
      check("d1_load_a", load_a, 1);
      check("d1_digit", key_digit, 1);
      check("d1_state", state_o, 1);
      release_key();
      check("d1_pulse_end", load_a, 0);
      press(4'h2);
      check("d2_load_a", load_a, 1);
      check("d2_digit", key_digit, 2);
      check("d2_cnt_a", cnt_a, 2);
      release_key();
      press(4'hA);
      check("mul_state", state_o, 2);
      check("mul_op_sel", op_sel, 2'b00);
      check("mul_no_load", {load_a, load_b}, 0);
      release_key();
      press(4'h3);
      check("b3_load_b", load_b, 1);
      check("b3_digit", key_digit, 3);
      check("b3_cnt_b", cnt_b, 1);
      release_key();
      press(4'hE);
      check("eq_start", start, 1);
      check("eq_busy", busy, 1);
      check("eq_state", state_o, 3);
      pulses = 1;
      repeat (4) begin
         @(negedge clk);
         key_level = 1'b0;
         @(posedge clk);
         #1;
         if (busy) pulses++;
         check("run_no_restart", start, 0);
      end
      @(negedge clk);
      op_done = 1'b1;
      @(posedge clk);
      #1;
      check("busy_cycles", pulses, 5);
      check("done_busy", busy, 0);
      check("done_valid", result_valid, 1);
      check("done_state", state_o, 4);
      @(negedge clk);
      op_done = 1'b0;
      @(posedge clk);
      #1;
      check("done_valid_held", result_valid, 1);

      // Digit in DONE: clear and load together
      press(4'h4);
      check("done_dig_clr_load", {clr_ops, load_a}, 2'b11);
      check("done_dig_valid", result_valid, 0);
      check("done_dig_state", state_o, 1);
      check("done_dig_cnts", {cnt_a, cnt_b}, 8'h10);
      check("done_dig_digit", key_digit, 4);
      release_key();

      // Clear in OPA
      press(4'hD);
      check("clr_opa", {clr_ops, state_o, cnt_a, cnt_b}, {1'b1, 3'd0, 8'h00});
      release_key();

      // Saturation at DIGITS_A=4
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         press(4'h9);
         if (load_a) pulses++;
         release_key();
      end
      check("sat_pulses", pulses, 4);
      check("sat_cnt_a", cnt_a, 4);

      // Clear in OPB
      press(4'hB);
      check("opb_add", {state_o, op_sel}, {3'd2, 2'b01});
      release_key();
      press(4'hD);
      check("clr_opb", {clr_ops, state_o, op_sel, cnt_a, cnt_b}, {1'b1, 3'd0, 2'b00, 8'h00});
      release_key();

      // 5,B,C,7,A,E: operator replacement then lock after first B digit
      press(4'h5); release_key();
      press(4'hB); release_key();
      press(4'hC);
      check("replace_op", op_sel, 2'b10);
      release_key();
      press(4'h7); release_key();
      press(4'hA);
      check("op_locked", op_sel, 2'b10);
      check("op_locked_state", state_o, 2);
      release_key();
      press(4'hE);
      check("sub_start", start, 1);
      release_key();

      // Keys in RUN are dropped
      press(4'hD);
      check("run_clear_ignored", {clr_ops, state_o, busy, cnt_a}, {1'b0, 3'd3, 1'b1, 4'd1});
      release_key();
      press(4'hE);
      check("run_eq_ignored", {start, busy}, 2'b01);
      release_key();

      // Key event coincident with op_done: op_done wins
      @(negedge clk);
      key_code  = 4'h8;
      key_level = 1'b1;
      op_done   = 1'b1;
      @(posedge clk);
      #1;
      check("coinc_state", state_o, 4);
      check("coinc_outs", {busy, result_valid, load_a, clr_ops}, 4'b0100);
      @(negedge clk);
      op_done   = 1'b0;
      key_level = 1'b0;
      @(posedge clk);
      #1;

      // Operator ignored in DONE, then clear
      press(4'hA);
      check("done_op_ignored", {state_o, result_valid}, {3'd4, 1'b1});
      release_key();
      press(4'hD);
      check("done_clear", {state_o, result_valid, clr_ops}, {3'd0, 1'b0, 1'b1});
      release_key();

      // Held key for 50 cycles gives a single load
      pulses = 0;
      @(negedge clk);
      key_code  = 4'h6;
      key_level = 1'b1;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (load_a) pulses++;
      end
      check("held_pulses", pulses, 1);
      check("held_cnt_a", cnt_a, 1);
      release_key();

      // Stray op_done outside RUN and reserved key F
      @(negedge clk);
      op_done = 1'b1;
      @(posedge clk);
      #1;
      check("stray_done", {state_o, result_valid, busy}, {3'd1, 2'b00});
      @(negedge clk);
      op_done = 1'b0;
      press(4'hF);
      check("key_f_ignored", {state_o, cnt_a, load_a, clr_ops}, {3'd1, 4'd1, 2'b00});
      release_key();

      // Reset asserted in RUN drops busy without waiting for a clock
      press(4'hA); release_key();
      press(4'h2); release_key();
      press(4'hE);
      check("pre_rst_busy", busy, 1);
      release_key();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_state", {state_o, clr_ops, cnt_a}, 0);
      @(negedge clk);
      rst = 1'b1;

`ifdef KEY_TIMEOUT_EN
      // Key 1 then 20 idle cycles -> abort to IDLE
      press(4'h1);
      release_key();
      pulses = 0;
      repeat (18) begin
         @(posedge clk);
         #1;
         if (clr_ops || state_o != 3'd1) pulses++;
      end
      check("tmo_not_early", pulses, 0);
      @(posedge clk);
      #1;
      check("tmo_fire", {clr_ops, state_o, cnt_a}, {1'b1, 3'd0, 4'd0});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of sequence");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_operand_sequencer.md
Name: keypad_operand_sequencer

Overview:
- Parametrised keypad front-end sequencer for the calculator datapath.
- Turns debounced key levels into operand-digit load pulses for A and B and an operator latch.
- Issues a start/done handshake to the arithmetic unit (Booth multiplier, adder/subtractor) and holds the result-valid indication until the next key.
- Supports multi-digit operands, operator selection, clear and operator replacement.

Parameters:
- DIGITS_A, 4, maximum decimal digits accepted for operand A (1..15)
- DIGITS_B, 4, maximum decimal digits accepted for operand B (1..15)
- CNT_W, 4, width of the digit counters; must hold max(DIGITS_A, DIGITS_B)
- TIMEOUT_CYC, 1000000, idle cycles before entry abort (only with KEY_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- key_level  in  1  debounced key-held level
- key_code  in  4  code of held key: 0-9 digit, A=mul, B=add, C=sub, D=clear, E='=', F=reserved
- op_done  in  1  arithmetic unit finished (1-cycle pulse)
- load_a  out  1  1-cycle pulse: shift digit key_digit into operand A register
- load_b  out  1  1-cycle pulse: shift digit into operand B register
- key_digit  out  4  registered digit value accompanying load_a/load_b
- clr_ops  out  1  1-cycle pulse: clear A, B and result registers
- op_sel  out  2  latched operator: 00 mul, 01 add, 10 sub
- start  out  1  1-cycle pulse launching the arithmetic unit
- busy  out  1  high from start until op_done accepted
- result_valid  out  1  result register holds a valid result
- cnt_a  out  CNT_W  digits accepted into A
- cnt_b  out  CNT_W  digits accepted into B
- state_o  out  3  current state encoding, for debug/display

Behaviour:
- Reset values: all outputs 0, op_sel=00, state IDLE, key_prev=0.
- Key event:
  - key_evt = key_level & ~key_prev; key_prev is a register.
  - Exactly one event per press; a held key produces no repeat.
  - All outputs are registered. The response appears one clock after the first cycle key_level is sampled high.
- States:
  - IDLE=0, OPA=1, OPB=2, RUN=3, DONE=4. Encodings 5-7 recover to IDLE with clr_ops.
- IDLE:
  - digit -> load_a, cnt_a=1, go OPA.
  - Operator and '=' are ignored.
  - clear -> clr_ops, counters 0.
- OPA:
  - digit with cnt_a<DIGITS_A -> load_a, cnt_a+1.
  - digit at cnt_a==DIGITS_A -> ignored (saturate, no pulse).
  - operator -> latch op_sel, go OPB, cnt_b=0.
  - '=' ignored.
- OPB:
  - digit -> load_b with the same saturation rule against DIGITS_B.
  - operator with cnt_b==0 -> replaces op_sel.
  - operator with cnt_b>0 -> ignored.
  - '=' with cnt_b>0 -> start=1 for one cycle, busy=1, go RUN.
  - '=' with cnt_b==0 -> ignored.
- RUN:
  - All keys are ignored, including clear; the arithmetic unit is never aborted.
  - op_done -> busy=0, result_valid=1, go DONE.
  - op_done in any state other than RUN is ignored.
- DONE:
  - result_valid is held high.
  - digit -> clr_ops and load_a in the same cycle, result_valid=0, cnt_a=1, cnt_b=0, go OPA.
  - clear -> clr_ops, result_valid=0, go IDLE.
  - operator and '=' are ignored.
- Clear key in IDLE/OPA/OPB: clr_ops pulse, cnt_a=cnt_b=0, op_sel=00, go IDLE.
- Code F is ignored in every state.
- key_evt coinciding with op_done in RUN: op_done is taken, the key is dropped.
- Reset asserted mid-operation: immediate return to reset values, including busy=0. Reset does not drive clr_ops; the datapath is reset by the same rst.

Optional Feature:
- Macro: KEY_TIMEOUT_EN.
- With it defined:
  - A counter of width clog2(TIMEOUT_CYC+1) runs while in OPA or OPB.
  - The counter is reset to 0 by every key_evt and by state entry.
  - On reaching TIMEOUT_CYC: clr_ops pulse, counters 0, go IDLE.
  - RUN and DONE never time out.
- Without it: no counter logic; OPA/OPB wait indefinitely.

Test Plan:
- Reset then keys 1,2,A,3,E with op_done 5 cycles after start -> load_a x2 (key_digit 1,2), op_sel=00, load_b x1 (digit 3), one start pulse, busy 5 cycles, result_valid=1.
- DIGITS_A=4, keys 9 x6 -> exactly 4 load_a pulses, cnt_a=4.
- Keys 5,B,C,7,E -> op_sel ends 10 (sub replaced add); a second operator after digit 7 is ignored; start fires.
- Key held high 50 cycles -> single load_a. Keys D and E during RUN -> no effect, busy stays until op_done.
- In DONE press digit 4 -> clr_ops and load_a in the same cycle, result_valid=0, state OPA. Clear in OPB -> IDLE, cnt_a=cnt_b=0.
- KEY_TIMEOUT_EN, TIMEOUT_CYC=20: key 1 then 20 idle cycles -> clr_ops, IDLE. Reset asserted in RUN -> busy=0 asynchronously.
